// File: rtl/rv_irq_ctrl_pkg.sv
// Shared constants for the rv32 machine-timer / interrupt controller:
// register byte offsets inside the 32-byte block, cause codes and the
// per-line trigger mode type.
package pkg_rv_irq;

    localparam logic [4:0] OFS_MTIME     = 5'h00;
    localparam logic [4:0] OFS_MTIMEH    = 5'h04;
    localparam logic [4:0] OFS_MTIMECMP  = 5'h08;
    localparam logic [4:0] OFS_MTIMECMPH = 5'h0C;
    localparam logic [4:0] OFS_IE        = 5'h10;
    localparam logic [4:0] OFS_IP        = 5'h14;
    localparam logic [4:0] OFS_MODE      = 5'h18;
    localparam logic [4:0] OFS_PRESC     = 5'h1C;

    localparam logic [31:0] CAUSE_MTI      = 32'd7;
    localparam logic [31:0] CAUSE_EXT_BASE = 32'd16;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } irqmode_t;

endpackage

// File: rtl/rv_irq_sync.sv
// NSYNC-flop synchroniser for one asynchronous interrupt line, plus a
// rising-edge strobe taken from the synchronised output.
module rv_irq_sync #(
    parameter int NSYNC = 2
) (
    input  logic clk,
    input  logic xreset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [NSYNC-1:0] chain;
    logic             q_d;

    // shift the raw line through the chain; keep one extra stage for edge detect
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[NSYNC-2:0], d};
            q_d   <= chain[NSYNC-1];
        end
    end

    assign q    = chain[NSYNC-1];
    assign rise = q & ~q_d;

endmodule

// File: rtl/rv_irq_ctrl.sv
// Machine timer + interrupt controller for the rv32 core.
// Register block on the core data bus, NIRQ synchronised external lines
// (level or edge per line) plus the machine timer, fixed priority
// (line 0 highest, timer lowest), single level of service (no nesting).
// Optional feature macro: RV_IRQ_PRESCALE_EN adds a 16-bit mtime prescaler
// at offset 0x1C; without it mtime advances every clock and 0x1C reads 0.
module rv_irq_ctrl
    import pkg_rv_irq::*;
#(
    parameter int          NIRQ  = 4,
    parameter int          NSYNC = 2,
    parameter logic [31:0] BASE  = 32'hffff8000
) (
    input  logic            clk,
    input  logic            xreset,
    input  logic [31:0]     d_adr,
    input  logic [31:0]     d_dw,
    input  logic [3:0]      d_we,
    input  logic            d_re,
    input  logic            d_rdy,
    output logic [31:0]     d_dr_o,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            int_ack,
    input  logic            mret,
    output logic            int_req,
    output logic [31:0]     int_cause
);

    // Bus handshake: an access happens only in a cycle with d_rdy high. A
    // full-word write (d_we == 4'b1111) to a hit address updates the register
    // at that edge; a read (d_re) to a hit address returns data on d_dr_o in
    // the next cycle; any other d_rdy cycle drives d_dr_o to 0 so the result
    // can be OR-ed onto the core read bus. With d_rdy low nothing changes.
    logic        hit;
    logic [4:0]  ofs;
    logic        wr_en;
    logic        rd_en;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
    logic        wr_ie, wr_ip, wr_mode;
    logic        unused_adr;

    assign hit         = (d_adr[31:5] == BASE[31:5]);
    assign ofs         = {d_adr[4:2], 2'b00};
    assign wr_en       = d_rdy && (d_we == 4'b1111) && hit;
    assign rd_en       = d_rdy && d_re && hit;
    assign wr_mtime_lo = wr_en && (ofs == OFS_MTIME);
    assign wr_mtime_hi = wr_en && (ofs == OFS_MTIMEH);
    assign wr_cmp_lo   = wr_en && (ofs == OFS_MTIMECMP);
    assign wr_cmp_hi   = wr_en && (ofs == OFS_MTIMECMPH);
    assign wr_ie       = wr_en && (ofs == OFS_IE);
    assign wr_ip       = wr_en && (ofs == OFS_IP);
    assign wr_mode     = wr_en && (ofs == OFS_MODE);
    assign unused_adr  = ^d_adr[1:0];

    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic [63:0]     timer_diff;
    logic            mti;
    logic [NIRQ:0]   ie;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] ip_edge;
    logic [NIRQ-1:0] ip_ext;
    logic [NIRQ-1:0] sync_q;
    logic [NIRQ-1:0] sync_rise;
    logic [NIRQ-1:0] w1c_mask;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ:0]   ip;
    logic [NIRQ:0]   pend;
    logic            any_pend;
    logic [31:0]     enc_cause;
    logic            in_service;
    logic            ack_take;
    logic            tick;
    logic [31:0]     presc_rd;
    logic [31:0]     rdata;

`ifdef RV_IRQ_PRESCALE_EN
    logic [15:0] presc;
    logic [15:0] presc_cnt;
    logic        wr_presc;

    assign wr_presc = wr_en && (ofs == OFS_PRESC);

    // down-counter: tick when it reaches 0, then reload; a PRESC write restarts it
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (wr_presc) begin
            presc     <= d_dw[15:0];
            presc_cnt <= d_dw[15:0];
        end else if (presc_cnt == 16'd0) begin
            presc_cnt <= presc;
        end else begin
            presc_cnt <= presc_cnt - 16'd1;
        end
    end

    assign tick     = (presc_cnt == 16'd0);
    assign presc_rd = {16'd0, presc};
`else
    assign tick     = 1'b1;
    assign presc_rd = '0;
`endif

    // mtime: a software write to either half wins over that cycle's tick
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= d_dw;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= d_dw;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // configuration registers written from the bus
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            mtimecmp <= '0;
            ie       <= '0;
            mode     <= '0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= d_dw;
            if (wr_cmp_hi) mtimecmp[63:32] <= d_dw;
            if (wr_ie)     ie              <= d_dw[NIRQ:0];
            if (wr_mode)   mode            <= d_dw[NIRQ-1:0];
        end
    end

    // timer pending is the sign of the wrapped distance to mtimecmp, one cycle late
    assign timer_diff = mtimecmp - mtime;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) mti <= 1'b0;
        else         mti <= timer_diff[63];
    end

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        rv_irq_sync #(.NSYNC(NSYNC)) u_sync (
            .clk   (clk),
            .xreset(xreset),
            .d     (irq_in[g]),
            .q     (sync_q[g]),
            .rise  (sync_rise[g])
        );
    end

    // an ack (or an ack together with mret) takes the request that int_cause names
    assign ack_take = int_ack && (int_req || mret);
    assign w1c_mask = wr_ip ? d_dw[NIRQ-1:0] : '0;

    // per-line view of pending and which edge bit an ack retires
    always_comb begin
        ip_ext  = '0;
        ack_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            ip_ext[i]  = (irqmode_t'(mode[i]) == EDGE) ? ip_edge[i] : sync_q[i];
            ack_clr[i] = ack_take && (int_cause == CAUSE_EXT_BASE + 32'(i));
        end
    end

    // edge-latched pending bits: a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) ip_edge <= '0;
        else         ip_edge <= (ip_edge & ~(w1c_mask | ack_clr)) | (mode & sync_rise);
    end

    assign ip       = {mti, ip_ext};
    assign pend     = ip & ie;
    assign any_pend = |pend;

    // fixed priority: lowest enabled line wins, timer only when no line is pending
    always_comb begin
        enc_cause = CAUSE_MTI;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pend[i]) enc_cause = CAUSE_EXT_BASE + 32'(i);
        end
    end

    // service state and request to the core; cause frozen while a request is up
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            in_service <= 1'b0;
            int_req    <= 1'b0;
            int_cause  <= '0;
        end else begin
            if (ack_take)  in_service <= 1'b1;
            else if (mret) in_service <= 1'b0;

            if (ack_take) int_req <= 1'b0;
            else          int_req <= !in_service && any_pend;

            if (!int_req && any_pend) int_cause <= enc_cause;
        end
    end

    // register read multiplexer
    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_MTIME:     rdata = mtime[31:0];
            OFS_MTIMEH:    rdata = mtime[63:32];
            OFS_MTIMECMP:  rdata = mtimecmp[31:0];
            OFS_MTIMECMPH: rdata = mtimecmp[63:32];
            OFS_IE:        rdata[NIRQ:0] = ie;
            OFS_IP:        rdata[NIRQ:0] = ip;
            OFS_MODE:      rdata[NIRQ-1:0] = mode;
            OFS_PRESC:     rdata = presc_rd;
            default:       rdata = '0;
        endcase
    end

    // registered read return, zero when this block is not the target
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)    d_dr_o <= '0;
        else if (rd_en) d_dr_o <= rdata;
        else if (d_rdy) d_dr_o <= '0;
    end

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// Bench for rv_irq_ctrl: directed scenarios plus randomized priority and
// mtime checks against a behavioural model held in the bench.
`timescale 1ns/1ps
module tb_rv_irq_ctrl;

    localparam int          NIRQ  = 4;
    localparam int          NSYNC = 2;
    localparam logic [31:0] BASE  = 32'hffff8000;

    localparam logic [4:0] A_MTIME = 5'h00, A_MTIMEH = 5'h04, A_CMP = 5'h08, A_CMPH = 5'h0C;
    localparam logic [4:0] A_IE = 5'h10, A_IP = 5'h14, A_MODE = 5'h18, A_PRESC = 5'h1C;

    logic            clk = 1'b0;
    logic            xreset = 1'b0;
    logic [31:0]     d_adr = '0;
    logic [31:0]     d_dw = '0;
    logic [3:0]      d_we = '0;
    logic            d_re = 1'b0;
    logic            d_rdy = 1'b1;
    logic [31:0]     d_dr_o;
    logic [NIRQ-1:0] irq_in = '0;
    logic            int_ack = 1'b0;
    logic            mret = 1'b0;
    logic            int_req;
    logic [31:0]     int_cause;

    int unsigned cyc = 0;
    int          nchecks = 0;
    int          nerrors = 0;
    logic [31:0] exp_q[$];

    rv_irq_ctrl #(.NIRQ(NIRQ), .NSYNC(NSYNC), .BASE(BASE)) dut (
        .clk      (clk),
        .xreset   (xreset),
        .d_adr    (d_adr),
        .d_dw     (d_dw),
        .d_we     (d_we),
        .d_re     (d_re),
        .d_rdy    (d_rdy),
        .d_dr_o   (d_dr_o),
        .irq_in   (irq_in),
        .int_ack  (int_ack),
        .mret     (mret),
        .int_req  (int_req),
        .int_cause(int_cause)
    );

    // clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic bus_write(input logic [4:0] ofs, input logic [31:0] data,
                             input logic [3:0] we, output int unsigned edge_no);
        d_adr = BASE + 32'(ofs);
        d_dw  = data;
        d_we  = we;
        @(negedge clk);
        edge_no = cyc;
        d_we  = 4'b0000;
        d_adr = '0;
    endtask

    task automatic bus_read(input logic [4:0] ofs, output logic [31:0] data,
                            output int unsigned edge_no);
        d_adr = BASE + 32'(ofs);
        d_re  = 1'b1;
        @(negedge clk);
        edge_no = cyc;
        data  = d_dr_o;
        d_re  = 1'b0;
        d_adr = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int waited);
        waited = 0;
        while (int_req !== 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // reference: first enabled active line in priority order, else timer
    function automatic logic [31:0] model_cause(input logic [NIRQ-1:0] act, input logic tmr);
        for (int i = 0; i < NIRQ; i++)
            if (act[i]) return 32'd16 + 32'(i);
        return tmr ? 32'd7 : 32'd0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] r;
        int unsigned e;
        #12;
        nchecks++;
        if ({int_req, int_cause, d_dr_o} !== 65'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: got req=%0b cause=%0h dr=%0h expected all 0", int_req, int_cause, d_dr_o);
        end
        @(negedge clk);
        xreset = 1'b1;
        @(negedge clk);
        bus_read(A_IE, r, e);
        nchecks++;
        if (r !== 32'd0) begin nerrors++; $display("FAIL reset_ie: got %0h expected 0", r); end
        bus_read(A_CMP, r, e);
        nchecks++;
        if (r !== 32'd0) begin nerrors++; $display("FAIL reset_cmp: got %0h expected 0", r); end
    endtask

    task automatic test_timer();
        int unsigned e, w, lat;
        int waited;
        bus_write(A_CMPH, 32'd1, 4'hF, e);
        bus_write(A_MTIME, 32'd0, 4'hF, w);
        bus_write(A_CMP, 32'd100, 4'hF, e);
        bus_write(A_CMPH, 32'd0, 4'hF, e);
        bus_write(A_IE, 32'(1 << NIRQ), 4'hF, e);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL timer_early: got req=%0b expected 0", int_req); end
        while (int_req !== 1'b1 && (cyc - w) < 400) @(negedge clk);
        lat = cyc - w;
        // mtime first exceeds 100 at 101, then one cycle for pending and one for the request
        nchecks++;
        if (lat !== 32'd103) begin nerrors++; $display("FAIL timer_latency: got %0d expected 103", lat); end
        nchecks++;
        if (int_cause !== 32'd7) begin nerrors++; $display("FAIL timer_cause: got %0d expected 7", int_cause); end
        pulse_ack();
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL timer_ack: got req=%0b expected 0", int_req); end
        idle(5);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL timer_in_service: got req=%0b expected 0", int_req); end
        pulse_mret();
        wait_req(3, waited);
        nchecks++;
        if (int_req !== 1'b1) begin nerrors++; $display("FAIL timer_after_mret: got req=%0b expected 1", int_req); end
        bus_write(A_CMPH, 32'd1, 4'hF, e);
        idle(3);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL timer_rearm_clear: got req=%0b expected 0", int_req); end
        bus_write(A_IE, 32'd0, 4'hF, e);
    endtask

    task automatic test_edge_level();
        int unsigned e, x, lat;
        int waited;
        logic [31:0] r;
        bus_write(A_MODE, 32'b0010, 4'hF, e);
        bus_write(A_IE, 32'b00010, 4'hF, e);
        irq_in[1] = 1'b1;
        @(negedge clk);
        x = cyc;
        irq_in[1] = 1'b0;
        while (int_req !== 1'b1 && (cyc - x) < 20) @(negedge clk);
        lat = cyc - x;
        nchecks++;
        if (lat !== 32'(NSYNC + 1)) begin nerrors++; $display("FAIL edge_latency: got %0d expected %0d", lat, NSYNC + 1); end
        nchecks++;
        if (int_cause !== 32'd17) begin nerrors++; $display("FAIL edge_cause: got %0d expected 17", int_cause); end
        bus_read(A_IP, r, e);
        nchecks++;
        if (r !== 32'h2) begin nerrors++; $display("FAIL edge_ip_held: got %0h expected 2", r); end
        pulse_ack();
        bus_read(A_IP, r, e);
        nchecks++;
        if (r !== 32'h0) begin nerrors++; $display("FAIL edge_ack_clears: got %0h expected 0", r); end
        pulse_mret();
        // level line 2 stays pending while high, even across ack/mret
        bus_write(A_IE, 32'b00110, 4'hF, e);
        irq_in[2] = 1'b1;
        wait_req(NSYNC + 6, waited);
        nchecks++;
        if (int_req !== 1'b1 || int_cause !== 32'd18) begin
            nerrors++; $display("FAIL level_req: got req=%0b cause=%0d expected 1/18", int_req, int_cause);
        end
        pulse_ack();
        pulse_mret();
        idle(1);
        nchecks++;
        if (int_req !== 1'b1) begin nerrors++; $display("FAIL level_persist: got req=%0b expected 1", int_req); end
        bus_read(A_IP, r, e);
        nchecks++;
        if (r !== 32'h4) begin nerrors++; $display("FAIL level_ip: got %0h expected 4", r); end
        irq_in[2] = 1'b0;
        idle(NSYNC + 2);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL level_drop: got req=%0b expected 0", int_req); end
        // edge set and W1C land on the same clock: the set must survive
        irq_in[1] = 1'b1;
        @(negedge clk);
        irq_in[1] = 1'b0;
        idle(NSYNC - 1);
        bus_write(A_IP, 32'h2, 4'hF, e);
        bus_read(A_IP, r, e);
        nchecks++;
        if (r !== 32'h2) begin nerrors++; $display("FAIL w1c_vs_set: got %0h expected 2", r); end
        bus_write(A_IP, 32'h2, 4'hF, e);
        bus_read(A_IP, r, e);
        nchecks++;
        if (r !== 32'h0) begin nerrors++; $display("FAIL w1c_clear: got %0h expected 0", r); end
        bus_write(A_IE, 32'd0, 4'hF, e);
        idle(2);
    endtask

    task automatic test_priority();
        int unsigned e;
        int waited;
        logic [31:0] r;
        bus_write(A_MODE, 32'b1001, 4'hF, e);
        bus_write(A_IE, 32'b01111, 4'hF, e);
        irq_in = 4'b1001;
        @(negedge clk);
        irq_in = 4'b0000;
        wait_req(NSYNC + 6, waited);
        nchecks++;
        if (int_req !== 1'b1 || int_cause !== 32'd16) begin
            nerrors++; $display("FAIL prio_first: got req=%0b cause=%0d expected 1/16", int_req, int_cause);
        end
        pulse_ack();
        pulse_mret();
        wait_req(3, waited);
        nchecks++;
        if (int_req !== 1'b1 || int_cause !== 32'd19) begin
            nerrors++; $display("FAIL prio_second: got req=%0b cause=%0d expected 1/19", int_req, int_cause);
        end
        pulse_ack();
        pulse_mret();
        idle(3);
        bus_read(A_IP, r, e);
        nchecks++;
        if (int_req !== 1'b0 || r !== 32'h0) begin
            nerrors++; $display("FAIL prio_drained: got req=%0b ip=%0h expected 0/0", int_req, r);
        end
        bus_write(A_MODE, 32'd0, 4'hF, e);
        bus_write(A_IE, 32'd0, 4'hF, e);
    endtask

    task automatic test_random_priority();
        int unsigned e;
        int waited;
        logic [NIRQ-1:0] ie_v, lines;
        logic            exp_req;
        logic [31:0]     exp_c;
        // an ack with no request up must not put the controller in service
        bus_write(A_IE, 32'd1, 4'hF, e);
        pulse_ack();
        irq_in[0] = 1'b1;
        wait_req(NSYNC + 6, waited);
        nchecks++;
        if (int_req !== 1'b1) begin nerrors++; $display("FAIL stray_ack_ignored: got req=%0b expected 1", int_req); end
        irq_in = '0;
        idle(NSYNC + 3);
        for (int it = 0; it < 10; it++) begin
            ie_v  = NIRQ'($urandom_range(0, (1 << NIRQ) - 1));
            lines = NIRQ'($urandom_range(1, (1 << NIRQ) - 1));
            bus_write(A_IE, 32'(ie_v), 4'hF, e);
            irq_in = lines;
            idle(NSYNC + 3);
            exp_req = |(ie_v & lines);
            exp_q.push_back(model_cause(ie_v & lines, 1'b0));
            nchecks++;
            if (int_req !== exp_req) begin
                nerrors++; $display("FAIL rand_req[%0d]: got %0b expected %0b (ie=%0h lines=%0h)", it, int_req, exp_req, ie_v, lines);
            end
            exp_c = exp_q.pop_front();
            if (exp_req) begin
                nchecks++;
                if (int_cause !== exp_c) begin
                    nerrors++; $display("FAIL rand_cause[%0d]: got %0d expected %0d", it, int_cause, exp_c);
                end
            end
            irq_in = '0;
            idle(NSYNC + 3);
        end
        bus_write(A_IE, 32'd0, 4'hF, e);
    endtask

    task automatic test_mtime();
        int unsigned e, w, rr, w2;
        logic [31:0] v, r;
        logic [63:0] m;
        for (int it = 0; it < 4; it++) begin
            v = $urandom_range(0, 32'h7fff_ffff);
            bus_write(A_MTIME, v, 4'hF, w);
            idle(it == 0 ? 0 : $urandom_range(1, 20));
            bus_read(A_MTIME, r, rr);
            nchecks++;
            if (r !== v + (rr - 1 - w)) begin
                nerrors++; $display("FAIL mtime_write_wins[%0d]: got %0h expected %0h", it, r, v + (rr - 1 - w));
            end
        end
        bus_write(A_MTIME, 32'hFFFF_FFFF, 4'b0001, e);
        bus_read(A_MTIME, r, rr);
        nchecks++;
        if (r !== v + (rr - 1 - w)) begin
            nerrors++; $display("FAIL byte_write_ignored: got %0h expected %0h", r, v + (rr - 1 - w));
        end
        // d_rdy low: the write must not land
        d_rdy = 1'b0;
        d_adr = BASE + 32'(A_IE);
        d_dw  = 32'h1F;
        d_we  = 4'hF;
        @(negedge clk);
        d_we  = 4'h0;
        d_rdy = 1'b1;
        bus_read(A_IE, r, e);
        nchecks++;
        if (r !== 32'd0) begin nerrors++; $display("FAIL rdy_low_write: got %0h expected 0", r); end
        // 64-bit wrap
        bus_write(A_MTIMEH, 32'hFFFF_FFFF, 4'hF, e);
        bus_write(A_MTIME, 32'hFFFF_FFFE, 4'hF, w2);
        idle(3);
        bus_read(A_MTIMEH, r, rr);
        m = 64'hFFFF_FFFF_FFFF_FFFE + 64'(rr - 1 - w2);
        nchecks++;
        if (r !== m[63:32]) begin nerrors++; $display("FAIL mtime_wrap_hi: got %0h expected %0h", r, m[63:32]); end
        bus_read(A_MTIME, r, rr);
        m = 64'hFFFF_FFFF_FFFF_FFFE + 64'(rr - 1 - w2);
        nchecks++;
        if (r !== m[31:0]) begin nerrors++; $display("FAIL mtime_wrap_lo: got %0h expected %0h", r, m[31:0]); end
    endtask

    task automatic test_regs();
        int unsigned e;
        logic [31:0] v, r;
        v = $urandom;
        bus_write(A_CMP, v, 4'hF, e);
        bus_read(A_CMP, r, e);
        nchecks++;
        if (r !== v) begin nerrors++; $display("FAIL cmp_lo_rb: got %0h expected %0h", r, v); end
        v = $urandom;
        bus_write(A_IE, v & 32'h0000_000F, 4'hF, e);
        bus_write(A_MODE, v, 4'hF, e);
        bus_read(A_MODE, r, e);
        nchecks++;
        if (r !== (v & 32'hF)) begin nerrors++; $display("FAIL mode_rb: got %0h expected %0h", r, v & 32'hF); end
        bus_write(A_IE, 32'hFFFF_FFFF, 4'hF, e);
        bus_write(A_CMPH, 32'd1, 4'hF, e);
        bus_read(A_IE, r, e);
        nchecks++;
        if (r !== 32'h1F) begin nerrors++; $display("FAIL ie_rb: got %0h expected 1f", r); end
        d_adr = BASE + 32'h40;
        d_re  = 1'b1;
        @(negedge clk);
        d_re  = 1'b0;
        nchecks++;
        if (d_dr_o !== 32'd0) begin nerrors++; $display("FAIL miss_read: got %0h expected 0", d_dr_o); end
`ifndef RV_IRQ_PRESCALE_EN
        bus_write(A_PRESC, 32'hFFFF, 4'hF, e);
        bus_read(A_PRESC, r, e);
        nchecks++;
        if (r !== 32'd0) begin nerrors++; $display("FAIL presc_absent: got %0h expected 0", r); end
`endif
        bus_write(A_IE, 32'd0, 4'hF, e);
        bus_write(A_MODE, 32'd0, 4'hF, e);
        idle(2);
    endtask

`ifdef RV_IRQ_PRESCALE_EN
    task automatic test_prescale();
        int unsigned e, p, w, rr, ticks;
        logic [31:0] r;
        bus_write(A_PRESC, 32'd3, 4'hF, p);
        bus_write(A_MTIME, 32'd0, 4'hF, w);
        idle($urandom_range(5, 30));
        bus_read(A_MTIME, r, rr);
        ticks = 0;
        for (int unsigned k = w + 1; k <= rr - 1; k++)
            if ((k - p) % 4 == 0) ticks++;
        nchecks++;
        if (r !== ticks) begin nerrors++; $display("FAIL presc_rate: got %0d expected %0d", r, ticks); end
        bus_read(A_PRESC, r, e);
        nchecks++;
        if (r !== 32'd3) begin nerrors++; $display("FAIL presc_rb: got %0h expected 3", r); end
        bus_write(A_PRESC, 32'd0, 4'hF, e);
    endtask
`endif

    task automatic test_ack_mret_reset();
        int unsigned e;
        int waited;
        logic [31:0] r;
        bus_write(A_IE, 32'd1, 4'hF, e);
        irq_in[0] = 1'b1;
        wait_req(NSYNC + 6, waited);
        pulse_ack();
        idle(1);
        int_ack = 1'b1;
        mret    = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        mret    = 1'b0;
        idle(1);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL ack_mret_same: got req=%0b expected 0", int_req); end
        idle(3);
        nchecks++;
        if (int_req !== 1'b0) begin nerrors++; $display("FAIL ack_mret_hold: got req=%0b expected 0", int_req); end
        pulse_mret();
        wait_req(3, waited);
        nchecks++;
        if (int_req !== 1'b1) begin nerrors++; $display("FAIL mret_release: got req=%0b expected 1", int_req); end
        pulse_ack();
        bus_read(A_IE, r, e);
        xreset = 1'b0;
        irq_in = '0;
        #1;
        nchecks++;
        if ({int_req, int_cause, d_dr_o} !== 65'd0) begin
            nerrors++; $display("FAIL reset_mid_service: got req=%0b cause=%0h dr=%0h expected all 0", int_req, int_cause, d_dr_o);
        end
        @(negedge clk);
        xreset = 1'b1;
        idle(NSYNC + 3);
        bus_read(A_IE, r, e);
        nchecks++;
        if (r !== 32'd0 || int_req !== 1'b0) begin
            nerrors++; $display("FAIL after_reset_ie: got ie=%0h req=%0b expected 0/0", r, int_req);
        end
        bus_read(A_IP, r, e);
        nchecks++;
        if ((r & 32'hF) !== 32'd0) begin nerrors++; $display("FAIL after_reset_ip: got %0h expected ext bits 0", r); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_edge_level();
        test_priority();
        test_random_priority();
        test_mtime();
        test_regs();
`ifdef RV_IRQ_PRESCALE_EN
        test_prescale();
`endif
        test_ack_mret_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
